// File: rtl/fma_vec.sv
// Multi-lane signed fused multiply-accumulate, two-stage pipeline with a
// valid/ready output handshake and optional saturation on the accumulator.
module fma_vec #(
    parameter int WIDTH       = 16,
    parameter int FIXED_POINT = 10,
    parameter int LANES       = 4,
    parameter int SATURATE    = 1
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic [LANES*3*WIDTH-1:0]   abc_in,
    input  logic                       valid_in,
    input  logic                       c_valid_in,
    input  logic                       fixed_mode_in,
    output logic                       ready_out,
    output logic [LANES*WIDTH-1:0]     out,
    output logic [LANES-1:0]           overflow_out,
    output logic                       valid_out,
    input  logic                       ready_in
);

    localparam int PW = 2 * WIDTH;
    localparam int SW = 2 * WIDTH + 1;

    localparam logic signed [SW-1:0] S_MAX = {{(WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] S_MIN = {{(WIDTH+2){1'b1}}, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0]     R_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]     R_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic                   r_s1_valid;
    logic                   r_s1_cvalid;
    logic                   r_s1_fixed;
    logic signed [PW-1:0]   r_prod [LANES];
    logic [WIDTH-1:0]       r_c    [LANES];
    logic [WIDTH-1:0]       r_out  [LANES];
    logic [LANES-1:0]       r_ovf;
    logic                   r_valid_out;

    logic                   w_en;
    logic signed [PW-1:0]   w_prod [LANES];
    logic signed [SW-1:0]   w_sum  [LANES];
    logic [WIDTH-1:0]       w_res  [LANES];
    logic [LANES-1:0]       w_ovf;

    // The whole pipeline advances as one; a stalled result blocks new beats.
    assign w_en         = !r_valid_out || ready_in;
    assign ready_out    = w_en;
    assign valid_out    = r_valid_out;
    assign overflow_out = r_ovf;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic signed [WIDTH-1:0] w_a;
        logic signed [WIDTH-1:0] w_b;
        logic signed [PW-1:0]    w_p;
        logic [SW-1:0]           w_addend;

        assign w_a       = abc_in[3*WIDTH*k + 2*WIDTH +: WIDTH];
        assign w_b       = abc_in[3*WIDTH*k +   WIDTH +: WIDTH];
        assign w_prod[k] = w_a * w_b;

        assign w_p      = r_s1_fixed ? (r_prod[k] >>> FIXED_POINT) : r_prod[k];
        assign w_addend = r_s1_cvalid ? {{(WIDTH+1){r_c[k][WIDTH-1]}}, r_c[k]}
                                      : {{(WIDTH+1){r_out[k][WIDTH-1]}}, r_out[k]};
        assign w_sum[k] = {w_p[PW-1], w_p} + w_addend;
        assign w_ovf[k] = (w_sum[k] > S_MAX) || (w_sum[k] < S_MIN);

        always_comb begin
            w_res[k] = w_sum[k][WIDTH-1:0];
            if (SATURATE != 0 && w_ovf[k]) begin
                w_res[k] = w_sum[k][SW-1] ? R_MIN : R_MAX;
            end
        end

        assign out[WIDTH*k +: WIDTH] = r_out[k];
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_s1_valid  <= 1'b0;
            r_s1_cvalid <= 1'b0;
            r_s1_fixed  <= 1'b0;
            r_ovf       <= '0;
            r_valid_out <= 1'b0;
            for (int k = 0; k < LANES; k++) begin
                r_prod[k] <= '0;
                r_c[k]    <= '0;
                r_out[k]  <= '0;
            end
        end else if (w_en) begin
            r_s1_valid  <= valid_in;
            r_valid_out <= r_s1_valid;
            // Operand registers only toggle for real beats.
            if (valid_in) begin
                r_s1_cvalid <= c_valid_in;
                r_s1_fixed  <= fixed_mode_in;
                for (int k = 0; k < LANES; k++) begin
                    r_prod[k] <= w_prod[k];
                    r_c[k]    <= abc_in[3*WIDTH*k +: WIDTH];
                end
            end
            if (r_s1_valid) begin
                r_ovf <= w_ovf;
                for (int k = 0; k < LANES; k++) begin
                    r_out[k] <= w_res[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_fma_vec.sv
// Self-checking bench for fma_vec: directed cases plus randomized traffic
// scored against an arithmetic reference model (saturating and wrapping DUTs).
module tb_fma_vec;

    localparam int W  = 16;
    localparam int FP = 10;
    localparam int L  = 4;

    localparam longint MAXV = (longint'(1) << (W-1)) - 1;
    localparam longint MINV = -(longint'(1) << (W-1));

    logic             clk   = 1'b0;
    logic             rst_n = 1'b1;
    logic [L*3*W-1:0] abc   = '0;
    logic             v     = 1'b0;
    logic             cv    = 1'b0;
    logic             fm    = 1'b0;
    logic             rdy   = 1'b1;

    logic             ready_s, ready_w, vo_s, vo_w;
    logic [L*W-1:0]   out_s, out_w;
    logic [L-1:0]     ov_s, ov_w;

    fma_vec #(.WIDTH(W), .FIXED_POINT(FP), .LANES(L), .SATURATE(1)) u_sat (
        .clk_in(clk), .rst_n_in(rst_n), .abc_in(abc), .valid_in(v), .c_valid_in(cv),
        .fixed_mode_in(fm), .ready_out(ready_s), .out(out_s), .overflow_out(ov_s),
        .valid_out(vo_s), .ready_in(rdy)
    );

    fma_vec #(.WIDTH(W), .FIXED_POINT(FP), .LANES(L), .SATURATE(0)) u_wrap (
        .clk_in(clk), .rst_n_in(rst_n), .abc_in(abc), .valid_in(v), .c_valid_in(cv),
        .fixed_mode_in(fm), .ready_out(ready_w), .out(out_w), .overflow_out(ov_w),
        .valid_out(vo_w), .ready_in(rdy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [L*W-1:0] os;
        logic [L*W-1:0] ow;
        logic [L-1:0]   vs;
        logic [L-1:0]   vw;
    } exp_t;

    exp_t   q[$];
    longint acc_s[L];
    longint acc_w[L];

    function automatic longint sx(input logic [W-1:0] x);
        return longint'($signed(x));
    endfunction

    // Divide by 2^FP rounding toward minus infinity.
    function automatic longint scale(input longint prod, input bit fixed);
        longint d;
        d = longint'(1) << FP;
        if (!fixed) return prod;
        if (prod >= 0) return prod / d;
        return -((-prod + d - 1) / d);
    endfunction

    function automatic longint clamp(input longint s);
        if (s > MAXV) return MAXV;
        if (s < MINV) return MINV;
        return s;
    endfunction

    function automatic longint wrapv(input longint s);
        longint m;
        m = s % (longint'(1) << W);
        if (m < 0) m += (longint'(1) << W);
        if (m > MAXV) m -= (longint'(1) << W);
        return m;
    endfunction

    function automatic logic [3*W-1:0] lane(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [W-1:0] c);
        return {a, b, c};
    endfunction

    function automatic logic [W-1:0] rval();
        if ($urandom_range(0, 1) == 1) return W'($urandom);
        return W'($urandom_range(0, 255)) - W'(128);
    endfunction

    function automatic logic [L*3*W-1:0] rbeat();
        logic [L*3*W-1:0] d;
        for (int k = 0; k < L; k++) d[3*W*k +: 3*W] = lane(rval(), rval(), rval());
        return d;
    endfunction

    task automatic model_accept(input logic [L*3*W-1:0] d, input bit c_v, input bit f);
        exp_t   e;
        longint a, b, c, p, s1, s2;
        for (int k = 0; k < L; k++) begin
            a  = sx(d[3*W*k + 2*W +: W]);
            b  = sx(d[3*W*k +   W +: W]);
            c  = sx(d[3*W*k       +: W]);
            p  = scale(a * b, f);
            s1 = p + (c_v ? c : acc_s[k]);
            s2 = p + (c_v ? c : acc_w[k]);
            e.vs[k] = (s1 > MAXV) || (s1 < MINV);
            e.vw[k] = (s2 > MAXV) || (s2 < MINV);
            acc_s[k] = clamp(s1);
            acc_w[k] = wrapv(s2);
            e.os[W*k +: W] = W'(acc_s[k]);
            e.ow[W*k +: W] = W'(acc_w[k]);
        end
        q.push_back(e);
    endtask

    task automatic model_reset();
        q.delete();
        for (int k = 0; k < L; k++) begin
            acc_s[k] = 0;
            acc_w[k] = 0;
        end
    endtask

    // One clock: drive at the falling edge, score whatever result is on the outputs.
    task automatic cycle(input bit iv, input bit icv, input bit ifm, input bit irdy,
                         input logic [L*3*W-1:0] d, output bit accepted);
        @(negedge clk);
        v = iv; cv = icv; fm = ifm; rdy = irdy; abc = d;
        #1;
        if (vo_s || vo_w) begin
            if (q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_valid: valid_out sat=%0b wrap=%0b with no result pending", vo_s, vo_w);
            end else begin
                n_checks++;
                if (vo_s !== 1'b1 || out_s !== q[0].os || ov_s !== q[0].vs)
                    $display("FAIL sb_sat: got v=%0b out=%h ovf=%b expected v=1 out=%h ovf=%b",
                             vo_s, out_s, ov_s, q[0].os, q[0].vs);
                else n_pass++;
                n_checks++;
                if (vo_w !== 1'b1 || out_w !== q[0].ow || ov_w !== q[0].vw)
                    $display("FAIL sb_wrap: got v=%0b out=%h ovf=%b expected v=1 out=%h ovf=%b",
                             vo_w, out_w, ov_w, q[0].ow, q[0].vw);
                else n_pass++;
                if (irdy) void'(q.pop_front());
            end
        end
        accepted = iv && ready_s;
        if (accepted) model_accept(d, icv, ifm);
    endtask

    task automatic drain();
        bit acc;
        for (int i = 0; i < 20 && (q.size() != 0 || vo_s); i++) cycle(0, 0, 0, 1, '0, acc);
        n_checks++;
        if (q.size() != 0) $display("FAIL drain: got %0d results undelivered expected 0", q.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        model_reset();
        #2;
        n_checks++;
        if (vo_s !== 1'b0 || out_s !== '0 || ov_s !== '0 || vo_w !== 1'b0 || out_w !== '0)
            $display("FAIL reset_outputs: got v=%0b out=%h ovf=%b expected all zero", vo_s, out_s, ov_s);
        else n_pass++;
        n_checks++;
        if (ready_s !== 1'b1) $display("FAIL reset_ready: got %0b expected 1", ready_s);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (ready_s !== 1'b1 || vo_s !== 1'b0) $display("FAIL post_reset: got ready=%0b v=%0b expected 1/0", ready_s, vo_s);
        else n_pass++;
    endtask

    task automatic test_int_accum();
        bit acc;
        logic [L*3*W-1:0] d;
        logic [W-1:0] exp_seq [4] = '{16'd17, 16'd21, 16'd25, 16'd29};
        d = rbeat(); d[0 +: 3*W] = lane(16'd3, 16'd4, 16'd5);
        cycle(1, 1, 0, 1, d, acc);
        d = rbeat(); d[0 +: 3*W] = lane(16'd2, 16'd2, 16'd0);
        cycle(1, 0, 0, 1, d, acc);
        n_checks++;
        if (vo_s !== 1'b0) $display("FAIL latency_early: got valid_out=%0b expected 0", vo_s);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            d = rbeat(); d[0 +: 3*W] = lane(16'd2, 16'd2, 16'hFFFF);
            cycle(i < 2, 0, 0, 1, d, acc);
            n_checks++;
            if (vo_s !== 1'b1 || out_s[W-1:0] !== exp_seq[i] || ov_s[0] !== 1'b0)
                $display("FAIL int_accum_%0d: got v=%0b lane0=%0d ovf=%0b expected v=1 lane0=%0d ovf=0",
                         i, vo_s, out_s[W-1:0], ov_s[0], exp_seq[i]);
            else n_pass++;
        end
        drain();
    endtask

    task automatic test_fixed();
        bit acc;
        logic [L*3*W-1:0] d;
        d = rbeat(); d[0 +: 3*W] = lane(16'h0400, 16'h0600, 16'h0200);
        cycle(1, 1, 1, 1, d, acc);
        d = rbeat(); d[0 +: 3*W] = lane(16'hF400, 16'h0400, 16'h0000);
        cycle(1, 1, 1, 1, d, acc);
        cycle(0, 0, 0, 1, '0, acc);
        n_checks++;
        if (out_s[W-1:0] !== 16'h0800 || ov_s[0] !== 1'b0)
            $display("FAIL fixed_pos: got %h ovf=%0b expected 0800 ovf=0", out_s[W-1:0], ov_s[0]);
        else n_pass++;
        cycle(0, 0, 0, 1, '0, acc);
        n_checks++;
        if (out_s[W-1:0] !== 16'hF400 || ov_s[0] !== 1'b0)
            $display("FAIL fixed_neg: got %h ovf=%0b expected F400 ovf=0", out_s[W-1:0], ov_s[0]);
        else n_pass++;
        drain();
    endtask

    task automatic test_saturate();
        bit acc;
        logic [L*3*W-1:0] d;
        d = rbeat(); d[0 +: 3*W] = lane(16'h4000, 16'h0004, 16'h0000);
        cycle(1, 1, 0, 1, d, acc);
        d = rbeat(); d[0 +: 3*W] = lane(16'hC000, 16'h0004, 16'h0000);
        cycle(1, 1, 0, 1, d, acc);
        cycle(0, 0, 0, 1, '0, acc);
        n_checks++;
        if (out_s[W-1:0] !== 16'h7FFF || ov_s[0] !== 1'b1 || out_w[W-1:0] !== 16'h0000 || ov_w[0] !== 1'b1)
            $display("FAIL sat_pos: got sat=%h/%0b wrap=%h/%0b expected 7FFF/1 0000/1",
                     out_s[W-1:0], ov_s[0], out_w[W-1:0], ov_w[0]);
        else n_pass++;
        cycle(0, 0, 0, 1, '0, acc);
        n_checks++;
        if (out_s[W-1:0] !== 16'h8000 || ov_s[0] !== 1'b1 || out_w[W-1:0] !== 16'h0000 || ov_w[0] !== 1'b1)
            $display("FAIL sat_neg: got sat=%h/%0b wrap=%h/%0b expected 8000/1 0000/1",
                     out_s[W-1:0], ov_s[0], out_w[W-1:0], ov_w[0]);
        else n_pass++;
        drain();
    endtask

    task automatic test_stall();
        bit acc, r;
        int sent = 0, delivered = 0, cyc = 0;
        logic [L*W-1:0] prev;
        bit prev_stalled = 0;
        while ((sent < 6 || q.size() != 0) && cyc < 40) begin
            r = !(cyc >= 3 && cyc <= 5);
            cycle(sent < 6, (sent == 0), $urandom_range(0, 1) == 1, r, rbeat(), acc);
            if (acc) sent++;
            if (vo_s && r) delivered++;
            if (!r && vo_s) begin
                n_checks++;
                if (ready_s !== 1'b0) $display("FAIL stall_ready: got %0b expected 0", ready_s);
                else n_pass++;
            end
            if (prev_stalled) begin
                n_checks++;
                if (out_s !== prev) $display("FAIL stall_hold: got %h expected %h", out_s, prev);
                else n_pass++;
            end
            prev_stalled = !r && vo_s;
            prev = out_s;
            cyc++;
        end
        n_checks++;
        if (delivered != 6 || sent != 6) $display("FAIL stall_count: got delivered=%0d sent=%0d expected 6/6", delivered, sent);
        else n_pass++;
        drain();
    endtask

    task automatic test_random();
        bit acc;
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 3) != 0, rbeat(), acc);
        drain();
    endtask

    task automatic test_reset_midstream();
        bit acc;
        logic [L*3*W-1:0] d;
        cycle(1, 1, 0, 1, rbeat(), acc);
        cycle(1, 0, 0, 1, rbeat(), acc);
        @(posedge clk);
        #2;
        v = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (vo_s !== 1'b0 || out_s !== '0 || ov_s !== '0 || out_w !== '0 || ready_s !== 1'b1)
            $display("FAIL midreset_clear: got v=%0b out=%h ovf=%b ready=%0b expected 0/0/0/1",
                     vo_s, out_s, ov_s, ready_s);
        else n_pass++;
        #4;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 1, '0, acc);
            n_checks++;
            if (vo_s !== 1'b0) $display("FAIL midreset_stale_%0d: got valid_out=%0b expected 0", i, vo_s);
            else n_pass++;
        end
        d = rbeat(); d[0 +: 3*W] = lane(16'd2, 16'd3, 16'd99);
        cycle(1, 0, 0, 1, d, acc);
        d = rbeat(); d[0 +: 3*W] = lane(16'd6, 16'd7, 16'd8);
        cycle(1, 1, 0, 1, d, acc);
        cycle(0, 0, 0, 1, '0, acc);
        n_checks++;
        if (out_s[W-1:0] !== 16'd6) $display("FAIL midreset_onto_zero: got %0d expected 6", out_s[W-1:0]);
        else n_pass++;
        cycle(0, 0, 0, 1, '0, acc);
        n_checks++;
        if (out_s[W-1:0] !== 16'd50 || vo_s !== 1'b1)
            $display("FAIL midreset_reload: got %0d v=%0b expected 50 v=1", out_s[W-1:0], vo_s);
        else n_pass++;
        drain();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_int_accum();
        test_fixed();
        test_saturate();
        test_stall();
        test_random();
        test_reset_midstream();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
